// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag/status bit positions and queue entry metadata.
package alu_pkg;

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned FLAGS_W = 3;
  localparam int unsigned STAT_W  = 4;

  // Opcodes carried alongside each result
  localparam logic [SEL_W-1:0] SEL_ADD = 3'b000;
  localparam logic [SEL_W-1:0] SEL_SUB = 3'b001;
  localparam logic [SEL_W-1:0] SEL_AND = 3'b010;
  localparam logic [SEL_W-1:0] SEL_OR  = 3'b011;
  localparam logic [SEL_W-1:0] SEL_XOR = 3'b100;
  localparam logic [SEL_W-1:0] SEL_SLT = 3'b101;
  localparam logic [SEL_W-1:0] SEL_SHL = 3'b110;
  localparam logic [SEL_W-1:0] SEL_SHR = 3'b111;

  // Bit positions inside the 3-bit flag field and the 4-bit status word
  localparam int unsigned FLAG_Z   = 2;
  localparam int unsigned FLAG_C   = 1;
  localparam int unsigned FLAG_V   = 0;
  localparam int unsigned STATUS_N = 3;

  // Per-entry metadata stored next to the result word
  typedef struct packed {
    logic [SEL_W-1:0]   sel;
    logic [FLAGS_W-1:0] flags;
  } meta_t;

  // Build the {n,z,c,v} status word from a sign bit and the raw flags
  function automatic logic [STAT_W-1:0] pack_status(input logic n, input logic [FLAGS_W-1:0] flags);
    logic [STAT_W-1:0] s;
    s = '0;
    s[STATUS_N] = n;
    s[FLAG_Z]   = flags[FLAG_Z];
    s[FLAG_C]   = flags[FLAG_C];
    s[FLAG_V]   = flags[FLAG_V];
    return s;
  endfunction

endpackage

// File: rtl/alu_status_reg.sv
// 4-bit {n,z,c,v} status register with load enable and asynchronous reset.
module alu_status_reg
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [STAT_W-1:0] d,
  output logic [STAT_W-1:0] q
);

  // Capture new status on load, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/alu_result_queue.sv
// Circular queue of ALU results with flags, sticky drop error and last-accepted status.
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       elk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic [WIDTH-1:0]           in_res,
  input  logic                       in_z,
  input  logic                       in_c,
  input  logic                       in_v,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_res,
  output logic [SEL_W-1:0]           out_sel,
  output logic [FLAGS_W-1:0]         out_flags,
  output logic [STAT_W-1:0]          status,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop_err,
  input  logic                       clr_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] res_mem  [DEPTH];
  meta_t            meta_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             drop;
  logic [FLAGS_W-1:0] in_flags;
  meta_t            in_meta;

  assign in_flags = {in_z, in_c, in_v};
  assign in_meta  = '{sel: in_sel, flags: in_flags};

  // Full queue still accepts when the head leaves in the same cycle
  assign in_ready  = (count < CW'(DEPTH)) || out_ready;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign drop      = in_valid && !in_ready;

  assign out_res   = res_mem[rd_ptr];
  assign out_sel   = meta_mem[rd_ptr].sel;
  assign out_flags = meta_mem[rd_ptr].flags;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge elk) begin
    if (push) begin
      res_mem[wr_ptr]  <= in_res;
      meta_mem[wr_ptr] <= in_meta;
    end
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge elk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear wins
  always_ff @(posedge elk or posedge rst) begin
    if (rst) begin
      drop_err <= 1'b0;
    end else if (drop) begin
      drop_err <= 1'b1;
    end else if (clr_err) begin
      drop_err <= 1'b0;
    end
  end

  alu_status_reg u_status (
    .clk  (elk),
    .rst  (rst),
    .load (push),
    .d    (pack_status(in_res[WIDTH-1], in_flags)),
    .q    (status)
  );

endmodule

// File: tb/tb_alu_result_queue.sv
// Randomized and directed bench for alu_result_queue against a queue-based reference model.
module tb_alu_result_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  sel;
    logic [2:0]  flags;
  } ent_t;

  logic        elk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_sel;
  logic [31:0] in_res;
  logic        in_z, in_c, in_v;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [2:0]  out_sel;
  logic [2:0]  out_flags;
  logic [3:0]  status;
  logic [2:0]  count;
  logic        drop_err;
  logic        clr_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  ent_t       mq[$];
  logic [3:0] m_status;
  logic       m_drop;
  int         max_count;

  alu_result_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .elk       (elk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_res    (in_res),
    .in_z      (in_z),
    .in_c      (in_c),
    .in_v      (in_v),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_sel   (out_sel),
    .out_flags (out_flags),
    .status    (status),
    .count     (count),
    .drop_err  (drop_err),
    .clr_err   (clr_err)
  );

  always #5 elk = ~elk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every observable output against the model
  task automatic compare_all();
    logic exp_rdy;
    exp_rdy = (mq.size() < DEPTH) || out_ready;
    check("count", 64'(count), 64'(mq.size()));
    check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("status", 64'(status), 64'(m_status));
    check("drop_err", 64'(drop_err), 64'(m_drop));
    if (mq.size() != 0) begin
      check("out_res", 64'(out_res), 64'(mq[0].res));
      check("out_sel", 64'(out_sel), 64'(mq[0].sel));
      check("out_flags", 64'(out_flags), 64'(mq[0].flags));
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_step();
    logic rdy;
    logic do_push;
    rdy     = (mq.size() < DEPTH) || out_ready;
    do_push = in_valid && rdy;
    if (mq.size() != 0 && out_ready) void'(mq.pop_front());
    if (do_push) begin
      mq.push_back('{res: in_res, sel: in_sel, flags: {in_z, in_c, in_v}});
      m_status = {in_res[31], in_z, in_c, in_v};
    end
    if (in_valid && !rdy) m_drop = 1'b1;
    else if (clr_err)     m_drop = 1'b0;
    if (mq.size() > max_count) max_count = mq.size();
  endtask

  task automatic cycle(input logic iv, input logic [2:0] sel, input logic [31:0] res,
                       input logic [2:0] fl, input logic ordy, input logic clr);
    @(negedge elk);
    in_valid  = iv;
    in_sel    = sel;
    in_res    = res;
    {in_z, in_c, in_v} = fl;
    out_ready = ordy;
    clr_err   = clr;
    #1;
    compare_all();
    model_step();
    @(posedge elk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 3'b000, 32'h0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_status = 4'b0000;
    m_drop   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sel = '0; in_res = '0;
    in_z = 1'b0; in_c = 1'b0; in_v = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0;
    model_reset();
    max_count = 0;
    repeat (2) @(posedge elk);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge elk);
    rst = 1'b0;

    // Single push into empty queue: visible only after the edge
    cycle(1'b1, 3'b001, 32'h0000_0000, 3'b110, 1'b0, 1'b0);
    check("p1_out_valid", 64'(out_valid), 64'd1);
    check("p1_out_res", 64'(out_res), 64'd0);
    check("p1_out_flags", 64'(out_flags), 64'(3'b110));
    check("p1_status", 64'(status), 64'(4'b0110));
    check("p1_count", 64'(count), 64'd1);
    cycle(1'b0, 3'b000, 32'h0, 3'b000, 1'b1, 1'b0);

    // Fill to capacity, then drain in order
    cycle(1'b1, 3'b000, 32'h1, 3'b000, 1'b0, 1'b0);
    cycle(1'b1, 3'b010, 32'h2, 3'b000, 1'b0, 1'b0);
    cycle(1'b1, 3'b011, 32'h3, 3'b000, 1'b0, 1'b0);
    cycle(1'b1, 3'b001, 32'h8000_0000, 3'b011, 1'b0, 1'b0);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_status_n", 64'(status[3]), 64'd1);

    // Drop while full and stalled, then clear
    cycle(1'b1, 3'b000, 32'h5, 3'b000, 1'b0, 1'b0);
    check("drop_set", 64'(drop_err), 64'd1);
    check("drop_count", 64'(count), 64'd4);
    check("drop_head", 64'(out_res), 64'd1);
    cycle(1'b0, 3'b000, 32'h0, 3'b000, 1'b0, 1'b1);
    check("drop_clr", 64'(drop_err), 64'd0);

    // Push and pop together while full
    cycle(1'b1, 3'b000, 32'h9, 3'b000, 1'b1, 1'b0);
    check("pp_count", 64'(count), 64'd4);
    check("pp_head", 64'(out_res), 64'd2);
    check("pp_drop", 64'(drop_err), 64'd0);
    repeat (3) cycle(1'b0, 3'b000, 32'h0, 3'b000, 1'b1, 1'b0);
    check("pp_nine", 64'(out_res), 64'd9);
    cycle(1'b0, 3'b000, 32'h0, 3'b000, 1'b1, 1'b0);
    idle();

    // Clear-and-drop in the same cycle: set wins
    repeat (4) cycle(1'b1, 3'b100, $urandom, 3'b001, 1'b0, 1'b0);
    cycle(1'b1, 3'b100, 32'h77, 3'b001, 1'b0, 1'b1);
    check("set_wins", 64'(drop_err), 64'd1);
    cycle(1'b0, 3'b000, 32'h0, 3'b000, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, 3'b000, 32'h0, 3'b000, 1'b1, 1'b0);

    // Pointer wrap: one-by-one push then pop
    max_count = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 3'(i), 32'(100 + i), 3'(i), 1'b0, 1'b0);
      cycle(1'b0, 3'b000, 32'h0, 3'b000, 1'b1, 1'b0);
    end
    check("wrap_max_count", 64'(max_count), 64'd1);

    // Asynchronous reset between edges with three queued entries
    repeat (3) cycle(1'b1, 3'b101, $urandom, 3'b111, 1'b0, 1'b0);
    @(negedge elk);
    in_valid = 1'b1; in_res = 32'hdead_beef; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_status", 64'(status), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    model_reset();
    @(posedge elk);
    #1;
    check("arst_push_ignored", 64'(count), 64'd0);
    @(negedge elk);
    rst = 1'b0;
    in_valid = 1'b0;
    cycle(1'b1, 3'b001, 32'h0000_abcd, 3'b010, 1'b0, 1'b0);
    check("arst_new_count", 64'(count), 64'd1);
    check("arst_new_head", 64'(out_res), 64'h0000_abcd);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] r;
      logic [1:0]  kind;
      kind = 2'($urandom_range(0, 3));
      r = $urandom;
      if (kind == 2'd0) r = 32'h0;
      cycle(1'($urandom_range(0, 3) != 0), 3'($urandom), r, 3'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_queue.md
ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as follows.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, 2..16.
REQ-003 Parameter WIDTH, default 32: result width.
REQ-004 elk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 in_valid  in  1  ALU result/flags valid this cycle.
REQ-007 in_sel  in  3  opcode that produced the result (3'b001 = subtract).
REQ-008 in_res  in  WIDTH  ALU result.
REQ-009 in_z, in_c, in_v  in  1 each  zero, carry, overflow flags from the ALU.
REQ-010 in_ready  out  1  queue can accept this cycle.
REQ-011 out_valid  out  1  head entry available.
REQ-012 out_ready  in  1  consumer takes head entry.
REQ-013 out_res  out  WIDTH; out_sel  out  3; out_flags  out  3 {z,c,v}: head entry fields.
REQ-014 status  out  4  {n,z,c,v} of the most recently accepted result.
REQ-015 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-016 drop_err  out  1  sticky: a result was lost.
REQ-017 clr_err  in  1  synchronous clear of drop_err.

Function
REQ-018 Push SHALL occur on an edge where in_valid && in_ready; pop SHALL occur on an edge where out_valid && out_ready.
REQ-019 in_ready SHALL equal (count < DEPTH) || out_ready, combinationally.
REQ-020 out_valid SHALL equal (count != 0); out_res, out_sel and out_flags SHALL be driven from the entry at the read pointer, and their value is don't-care when empty.
REQ-021 Storage SHALL be a circular buffer with write and read pointers that wrap modulo DEPTH.
REQ-022 Count update: push only gives +1; pop only gives -1; push and pop together leave count unchanged.
REQ-023 Simultaneous push and pop when full SHALL be accepted: the head leaves and the new entry is written to the freed slot.
REQ-024 Simultaneous push and pop when empty is impossible, because out_valid is 0; the push SHALL proceed alone.
REQ-025 Latency: a result pushed into an empty queue at edge k SHALL present out_valid=1 with its data after edge k, with no bypass in the same cycle.
REQ-026 in_valid while in_ready=0: the result SHALL be discarded, drop_err SHALL be set at that edge, and pointers, count and status SHALL be unchanged.
REQ-027 drop_err SHALL hold until an edge with clr_err=1; if clr_err=1 and a drop occur at the same edge, drop_err SHALL be 1 (set wins).
REQ-028 status SHALL update on every push to {in_res[WIDTH-1], in_z, in_c, in_v} and hold otherwise.
REQ-029 The flags SHALL be stored as received, without recomputation; in_sel SHALL be stored unfiltered.

Reset
REQ-030 While rst=1, asynchronously: pointers=0, count=0, out_valid=0, status=4'b0000, drop_err=0; memory contents are don't-care.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries; the first push after release SHALL be treated as an entry into an empty queue.
REQ-032 With rst=1, in_ready SHALL equal out_ready || 1, so 1; pushes at edges while rst=1 SHALL be ignored.

Structure
REQ-033 Shared package alu_pkg SHALL hold: opcode constants (SEL_SUB=3'b001, others), flag bit indices (Z=2, C=1, V=0), and status bit index N=3.
REQ-034 One sub-module is natural: alu_status_reg, a 4-bit status register with load enable and async reset; all other logic is flat in alu_result_queue.

Verification
REQ-035 Push res=32'h0000_0000 with z=1, c=1, v=0, sel=001 into an empty queue -> next cycle out_valid=1, out_res=0, out_flags=3'b110, status=4'b0110, count=1.
REQ-036 Four pushes with res=1,2,3,0x8000_0000 and out_ready=0 -> count=4, in_ready=0, status[3]=1; then drain -> values appear in order 1,2,3,0x8000_0000.
REQ-037 Queue full, out_ready=0, push res=5 -> drop_err=1, count=4, head unchanged; then clr_err=1 for one cycle -> drop_err=0.
REQ-038 Queue full, out_ready=1, push res=9 in the same cycle -> head advances, count stays 4, 9 emerges after three further pops; drop_err=0.
REQ-039 Pointer wrap: push and pop 10 entries one by one -> data in order, count never exceeds 1.
REQ-040 count=3, rst pulsed asynchronously between edges -> out_valid=0, count=0, status=0 immediately; a push after release yields count=1 with the new data at the head.
